// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response bundle for the registered MIPS ALU.
//
// Request side : in_valid, in_ready, a, b, alu_control
// Response side: out_valid, out_ready, result, result_hi, zero, ovf, illegal
//
// Modports:
//   master - operand fetch / writeback side (drives requests, accepts results)
//   slave  - the ALU itself
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, result_hi, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered MIPS ALU with valid/ready handshake.
//
// Single-cycle ops (ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA)
// land in the output register on the accepting edge. MULTU runs an
// iterative shift-add multiply over WIDTH cycles and returns HI:LO.
// Unsupported codes complete as single-cycle ops with illegal=1.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_pipe_if.slave (request, response and flags)
//
// Build option: define ALU_PIPE_OVF_EN to build signed-overflow detection
// for ADD/SUB; otherwise ovf is tied to 0.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    alu_pipe_if.slave   bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

`ifdef ALU_PIPE_OVF_EN
    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // a - b overflows when operand signs differ and result sign flips from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction
`endif

    logic [0:0]         state;
    logic [SHW-1:0]     count;
    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] acc;

    logic               vld_p1;
    logic [WIDTH-1:0]   result_p1;
    logic [WIDTH-1:0]   result_hi_p1;
    logic               zero_p1;
    logic               illegal_p1;

    logic               in_ready_c;
    logic               accept;
    logic               is_multu;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res_c;
    logic               ill_c;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic               mul_last;

    assign in_ready_c = rst_n && (state == IDLE) && (!vld_p1 || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_c;
    assign is_multu   = (bus.alu_control == OP_MULTU);

    assign a_s   = bus.a;
    assign b_s   = bus.b;
    assign shamt = bus.b[SHW-1:0];
    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;

    always_comb begin
        res_c = '0;
        ill_c = 1'b0;
        unique case (bus.alu_control)
            OP_ADD, OP_ADDU: res_c = sum;
            OP_SUB, OP_SUBU: res_c = diff;
            OP_AND:          res_c = bus.a & bus.b;
            OP_OR:           res_c = bus.a | bus.b;
            OP_XOR:          res_c = bus.a ^ bus.b;
            OP_NOR:          res_c = ~(bus.a | bus.b);
            OP_SLT:          res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:         res_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:          res_c = bus.a << shamt;
            OP_SRL:          res_c = bus.a >> shamt;
            OP_SRA:          res_c = a_s >>> shamt;
            OP_MULTU:        res_c = '0;
            default:         ill_c = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_OVF_EN
    logic ovf_c;
    logic ovf_p1;

    always_comb begin
        ovf_c = 1'b0;
        if (bus.alu_control == OP_ADD)
            ovf_c = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum[WIDTH-1]);
        else if (bus.alu_control == OP_SUB)
            ovf_c = sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], diff[WIDTH-1]);
    end
`endif

    // Right-shifting shift-add: acc = {HI, LO}, LO starts as the multiplier
    // and its low bit selects whether A is added into HI each step. After
    // WIDTH steps the multiplier has been fully shifted out and acc holds
    // the full product.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mul_a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign mul_last = (count == SHW'(WIDTH - 1));

    // ---- multiply datapath (no reset needed; always loaded before use) ----
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (accept && is_multu) begin
                mul_a <= bus.a;
                acc   <= {{WIDTH{1'b0}}, bus.b};
            end
        end else begin
            acc <= mul_next;
        end
    end

    // ---- control and output register (stage p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            vld_p1       <= 1'b0;
            result_p1    <= '0;
            result_hi_p1 <= '0;
            zero_p1      <= 1'b0;
            illegal_p1   <= 1'b0;
`ifdef ALU_PIPE_OVF_EN
            ovf_p1       <= 1'b0;
`endif
        end else begin
            if (vld_p1 && bus.out_ready)
                vld_p1 <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    if (is_multu) begin
                        count <= '0;
                        state <= MUL;
                    end else begin
                        vld_p1       <= 1'b1;
                        result_p1    <= res_c;
                        result_hi_p1 <= '0;
                        zero_p1      <= (res_c == '0);
                        illegal_p1   <= ill_c;
`ifdef ALU_PIPE_OVF_EN
                        ovf_p1       <= ovf_c;
`endif
                    end
                end
            end else begin
                count <= count + 1'b1;
                if (mul_last) begin
                    vld_p1       <= 1'b1;
                    result_p1    <= mul_next[WIDTH-1:0];
                    result_hi_p1 <= mul_next[2*WIDTH-1:WIDTH];
                    zero_p1      <= (mul_next == '0);
                    illegal_p1   <= 1'b0;
`ifdef ALU_PIPE_OVF_EN
                    ovf_p1       <= 1'b0;
`endif
                    state        <= IDLE;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p1;
    assign bus.result    = result_p1;
    assign bus.result_hi = result_hi_p1;
    assign bus.zero      = zero_p1;
    assign bus.illegal   = illegal_p1;
`ifdef ALU_PIPE_OVF_EN
    assign bus.ovf       = ovf_p1;
`else
    assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (WIDTH=32).
// Expected values are hand-computed constants; the MULTU product for
// the arbitrary-operand case comes from a 64-bit multiply in the bench.
module tb_alu_pipe;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

`ifdef ALU_PIPE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus ();
    alu_pipe #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, let it be accepted.
    task automatic present(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        int w;
        w = 0;
        bus.alu_control = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk({tag, " ready timeout"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ez, input logic ei,
                          input logic eo, input string tag);
        present(op, a, b, tag);
        chk({tag, " valid"},   64'(bus.out_valid), 64'd1);
        chk({tag, " result"},  64'(bus.result),    64'(er));
        chk({tag, " hi"},      64'(bus.result_hi), 64'd0);
        chk({tag, " zero"},    64'(bus.zero),      64'(ez));
        chk({tag, " illegal"}, 64'(bus.illegal),   64'(ei));
        chk({tag, " ovf"},     64'(bus.ovf),       64'(eo & OVF_ON));
    endtask

    task automatic mul_test(input logic [31:0] a, input logic [31:0] b, input string tag);
        int   lat;
        logic rdy_seen;
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        present(OP_MULTU, a, b, tag);
        lat = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        chk({tag, " latency"},     64'(lat),           64'd32);
        chk({tag, " ready in MUL"}, 64'(rdy_seen),     64'd0);
        chk({tag, " lo"},          64'(bus.result),    64'(prod[31:0]));
        chk({tag, " hi"},          64'(bus.result_hi), 64'(prod[63:32]));
        chk({tag, " zero"},        64'(bus.zero),      64'(prod == 64'd0));
        chk({tag, " illegal"},     64'(bus.illegal),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.alu_control = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst result",    64'(bus.result),    64'd0);
        chk("rst hi",        64'(bus.result_hi), 64'd0);
        chk("rst zero",      64'(bus.zero),      64'd0);
        chk("rst ovf",       64'(bus.ovf),       64'd0);
        chk("rst illegal",   64'(bus.illegal),   64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle in_ready", 64'(bus.in_ready), 64'd1);

        // Single-cycle ops, issued back to back
        run_op(OP_ADD,  32'd1,        32'd1,        32'd2,        1'b0, 1'b0, 1'b0, "add");
        run_op(OP_SUB,  32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0, "sub zero");
        run_op(OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0, "slt");
        run_op(OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0, "sltu");
        run_op(OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0, "sra");
        run_op(OP_SRL,  32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0, 1'b0, "srl");
        run_op(OP_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0, "sll");
        run_op(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, "and");
        run_op(OP_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0, "or");
        run_op(OP_XOR,  32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 1'b0, 1'b0, 1'b0, "xor");
        run_op(OP_NOR,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "nor");
        run_op(6'b111111, 32'd1,      32'd1,        32'd0,        1'b1, 1'b1, 1'b0, "illegal");
        run_op(OP_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1, "add ovf");
        run_op(OP_ADDU, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0, "addu");
        run_op(OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, "sub ovf");
        run_op(OP_SUBU, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "subu");
        tick();
        chk("drain out_valid", 64'(bus.out_valid), 64'd0);

        // MULTU
        mul_test(32'hFFFFFFFF, 32'd2,        "multu max");
        mul_test(32'hDEADBEEF, 32'h12345678, "multu mix");
        mul_test(32'd0,        32'hFFFFFFFF, "multu zero");

        // MULTU aborted by reset at cycle 10
        present(OP_MULTU, 32'hFFFFFFFF, 32'd2, "abort");
        repeat (9) tick();
        chk("abort mid ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #2;
        chk("abort rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort rst result",    64'(bus.result),    64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("abort no valid", 64'(seen),          64'd0);
        chk("abort result",   64'(bus.result),    64'd0);
        chk("abort hi",       64'(bus.result_hi), 64'd0);
        chk("abort idle",     64'(bus.in_ready),  64'd1);

        // Backpressure: ADD, OR, XOR with out_ready low for 3 cycles
        bus.out_ready = 1'b0;
        present(OP_ADD, 32'd3, 32'd4, "bp add");
        chk("bp add valid", 64'(bus.out_valid), 64'd1);
        chk("bp add result", 64'(bus.result), 64'd7);
        bus.alu_control = OP_OR;
        bus.a = 32'h30;
        bus.b = 32'h0C;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp stall ready", 64'(bus.in_ready), 64'd0);
            tick();
            chk("bp hold result", 64'(bus.result), 64'd7);
            chk("bp hold valid",  64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp release ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp or valid",  64'(bus.out_valid), 64'd1);
        chk("bp or result", 64'(bus.result),    64'h3C);
        bus.alu_control = OP_XOR;
        bus.a = 32'hFF;
        bus.b = 32'h0F;
        tick();
        bus.in_valid = 1'b0;
        chk("bp xor valid",  64'(bus.out_valid), 64'd1);
        chk("bp xor result", 64'(bus.result),    64'hF0);
        tick();
        chk("bp drained", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor of the single-cycle MIPS ALU.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result with flags.
- Adds signed/unsigned compares, shifts, and an iterative unsigned multiply (MULTU) producing a HI/LO pair.
- Sits between decode/operand fetch and writeback in the MIPS datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shift amount in b[SHW-1:0].
- alu_control  input  6  operation select (MIPS funct encoding).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  result; LO word for MULTU.
- result_hi  output  WIDTH  HI word for MULTU; 0 for all other ops.
- zero  output  1  result==0 (MULTU: HI and LO both 0).
- ovf  output  1  signed overflow on ADD/SUB (see Optional Feature).
- illegal  output  1  alu_control not a supported code.

Behaviour:
- Reset (rst_n=0, async): state IDLE; out_valid, result, result_hi, zero, ovf, illegal = 0; in_ready = 0 while rst_n low.
- Opcodes:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU: modulo 2^WIDTH.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101010 SLT (signed), 101011 SLTU (unsigned): result 1 or 0, zero-extended.
  - 000000 SLL, 000010 SRL, 000011 SRA: shift a by b[SHW-1:0].
  - 011001 MULTU: unsigned a*b, {result_hi,result} = 2*WIDTH-bit product.
  - Any other code: result=0, result_hi=0, zero=1, illegal=1; not an error stall.
- Handshake:
  - Accept when in_valid && in_ready on a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output transfer when out_valid && out_ready.
  - While out_valid && !out_ready, result and all flags hold stable.
- Single-cycle ops: accepted at edge N; result and flags registered at edge N; out_valid high from edge N.
  - Throughput: 1 op/cycle when out_ready is held high.
  - Simultaneous output transfer and new accept in the same cycle is legal: the output register reloads, out_valid stays 1.
- MULTU FSM: IDLE -> MUL -> IDLE.
  - On accept: latch a and b; clear the HI:LO accumulator; count=0; enter MUL. in_ready=0 throughout MUL.
  - MUL: one shift-add step per cycle; count increments.
  - On the step with count==WIDTH-1: load the output register, set out_valid, return to IDLE.
  - out_valid rises at edge N+WIDTH for acceptance at edge N.
- Flags registered with result; result_hi forced 0 for non-MULTU ops.
- rst_n asserted mid-MUL: operation aborted, no result produced; state IDLE after release.
- in_valid with in_ready=0: no effect; the requester must hold its operands.

Optional Feature:
- Macro ALU_PIPE_OVF_EN.
  - Defined: ovf=1 on ADD/SUB when the two's-complement result overflows; 0 for ADDU/SUBU and all other ops. Registered and held like result.
  - Undefined: ovf tied to 0 and no overflow logic is built.

Test Plan:
- ADD a=1 b=1 -> result=2, zero=0, illegal=0; out_valid 1 cycle after accept. SUB a=5 b=5 -> result=0, zero=1.
- SLT a=0xFFFFFFFF b=1 -> result=1; SLTU same operands -> result=0. SRA a=0x80000000 b=4 -> 0xF8000000; SRL -> 0x08000000.
- MULTU a=0xFFFFFFFF b=2 -> result_hi=0x00000001, result=0xFFFFFFFE, out_valid exactly 32 cycles after accept, in_ready=0 during MUL. Repeat with rst_n pulsed low at cycle 10 -> out_valid never asserts, outputs 0.
- Back-to-back ADD, OR, XOR with out_ready=0 for 3 cycles -> first result held stable, in_ready=0, no op lost or duplicated; results appear in order after out_ready=1.
- alu_control=6'b111111 -> result=0, zero=1, illegal=1. ADD 0x7FFFFFFF+1 -> ovf=1 with ALU_PIPE_OVF_EN defined, ovf=0 without it; ADDU same operands -> ovf=0 in both builds.
